mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-granular main memory between the
// instruction cache (port 0) and the data cache (port 1).
module mem_arbiter #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [ADDR_LEN-1:0]                    i_p0_addr,
  input  logic                                   i_p0_rd_req,
  input  logic                                   i_p0_wr_req,
  input  logic [(2**LINE_ADDR_LEN)-1:0][31:0]    i_p0_wr_line,
  output logic [(2**LINE_ADDR_LEN)-1:0][31:0]    o_p0_rd_line,
  output logic                                   o_p0_gnt,
  input  logic [ADDR_LEN-1:0]                    i_p1_addr,
  input  logic                                   i_p1_rd_req,
  input  logic                                   i_p1_wr_req,
  input  logic [(2**LINE_ADDR_LEN)-1:0][31:0]    i_p1_wr_line,
  output logic [(2**LINE_ADDR_LEN)-1:0][31:0]    o_p1_rd_line,
  output logic                                   o_p1_gnt,
  output logic [ADDR_LEN-1:0]                    o_mem_addr,
  output logic                                   o_mem_rd_req,
  output logic                                   o_mem_wr_req,
  output logic [(2**LINE_ADDR_LEN)-1:0][31:0]    o_mem_wr_line,
  input  logic [(2**LINE_ADDR_LEN)-1:0][31:0]    i_mem_rd_line,
  input  logic                                   i_mem_gnt
);

  localparam int WORDS = 2**LINE_ADDR_LEN;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                  r_state, w_state_next;
  logic                    r_owner, w_owner_next;
  logic                    r_op_wr, w_op_wr_next;
  logic                    r_last_owner, w_last_owner_next;
  logic [ADDR_LEN-1:0]     r_addr, w_addr_next;
  logic [WORDS-1:0][31:0]  r_wr_line, w_wr_line_next;
  logic                    r_mem_rd_req, w_mem_rd_req_next;
  logic                    r_mem_wr_req, w_mem_wr_req_next;
  logic                    r_p0_gnt, w_p0_gnt_next;
  logic                    r_p1_gnt, w_p1_gnt_next;

  logic w_p0_req;
  logic w_p1_req;
  logic w_winner;
  logic w_winner_wr;

  assign w_p0_req = i_p0_rd_req | i_p0_wr_req;
  assign w_p1_req = i_p1_rd_req | i_p1_wr_req;
  // Port 1 wins when it is alone, or on a tie when port 0 was served last.
  assign w_winner    = w_p1_req & (~w_p0_req | ~r_last_owner);
  assign w_winner_wr = w_winner ? i_p1_wr_req : i_p0_wr_req;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_op_wr      <= 1'b0;
      r_last_owner <= 1'b1;
      r_addr       <= '0;
      r_wr_line    <= '0;
      r_mem_rd_req <= 1'b0;
      r_mem_wr_req <= 1'b0;
      r_p0_gnt     <= 1'b0;
      r_p1_gnt     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_op_wr      <= w_op_wr_next;
      r_last_owner <= w_last_owner_next;
      r_addr       <= w_addr_next;
      r_wr_line    <= w_wr_line_next;
      r_mem_rd_req <= w_mem_rd_req_next;
      r_mem_wr_req <= w_mem_wr_req_next;
      r_p0_gnt     <= w_p0_gnt_next;
      r_p1_gnt     <= w_p1_gnt_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_owner_next      = r_owner;
    w_op_wr_next      = r_op_wr;
    w_last_owner_next = r_last_owner;
    w_addr_next       = r_addr;
    w_wr_line_next    = r_wr_line;
    w_mem_rd_req_next = r_mem_rd_req;
    w_mem_wr_req_next = r_mem_wr_req;
    w_p0_gnt_next     = 1'b0;
    w_p1_gnt_next     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_p0_req | w_p1_req) begin
          w_state_next      = S_BUSY;
          w_owner_next      = w_winner;
          w_op_wr_next      = w_winner_wr;
          w_last_owner_next = w_winner;
          w_addr_next       = w_winner ? i_p1_addr : i_p0_addr;
          w_wr_line_next    = w_winner ? i_p1_wr_line : i_p0_wr_line;
          w_mem_rd_req_next = ~w_winner_wr;
          w_mem_wr_req_next = w_winner_wr;
        end
      end
      S_BUSY: begin
        if (i_mem_gnt) begin
          w_state_next      = S_DONE;
          w_mem_rd_req_next = 1'b0;
          w_mem_wr_req_next = 1'b0;
          w_p0_gnt_next     = ~r_owner;
          w_p1_gnt_next     = r_owner;
        end
      end
      // Requests stay low for this cycle so main_mem restarts its delay count.
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_mem_addr    = r_addr;
  assign o_mem_wr_line = r_wr_line;
  assign o_mem_rd_req  = r_mem_rd_req;
  assign o_mem_wr_req  = r_mem_wr_req;
  assign o_p0_gnt      = r_p0_gnt;
  assign o_p1_gnt      = r_p1_gnt;
  assign o_p0_rd_line  = i_mem_rd_line;
  assign o_p1_rd_line  = i_mem_rd_line;

endmodule
